// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED sequencer: modes, FSM states and ping-pong direction.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_FLASH    = 2'd0,
    MODE_SHIFT_L  = 2'd1,
    MODE_SHIFT_R  = 2'd2,
    MODE_PINGPONG = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // Headroom bits so CNT_BASE << 3 never overflows the limit.
  localparam int LIM_EXTRA_W = 3;

endpackage

// File: rtl/led_seq_prescaler.sv
// Step prescaler: counts while running, wraps on count >= limit-1, registers the tick.
// o_fire is the tick about to be registered, so the pattern can update on the same edge.
module led_seq_prescaler
  import led_seq_pkg::*;
#(
  parameter int          NB_COUNT = 32,
  parameter int unsigned CNT_BASE = 32'd50000000
) (
  input  logic       clock,
  input  logic       i_reset,
  input  logic       i_run,
  input  logic       i_force,
  input  logic [1:0] i_speed_sel,
  output logic       o_fire,
  output logic       o_tick
);

  localparam int                LIM_W    = NB_COUNT + LIM_EXTRA_W;
  localparam logic [LIM_W-1:0]  BASE_EXT = LIM_W'(CNT_BASE);
  localparam logic [LIM_W-1:0]  LIM_ONE  = {{(LIM_W-1){1'b0}}, 1'b1};
  localparam logic [NB_COUNT-1:0] CNT_ONE = {{(NB_COUNT-1){1'b0}}, 1'b1};

  logic [NB_COUNT-1:0] count_q, count_d;
  logic                tick_q, tick_d;
  logic [LIM_W-1:0]    limit_s;
  logic [LIM_W-1:0]    last_s;
  logic                wrap_s;

  // Period compare and next counter/tick values.
  always_comb begin
    limit_s = BASE_EXT << i_speed_sel;
    last_s  = limit_s - LIM_ONE;
    wrap_s  = ({{LIM_EXTRA_W{1'b0}}, count_q} >= last_s);
    count_d = '0;
    tick_d  = 1'b0;
    if (i_run) begin
      if (wrap_s) begin
        count_d = '0;
        tick_d  = 1'b1;
      end else begin
        count_d = count_q + CNT_ONE;
        tick_d  = 1'b0;
      end
    end else begin
      // Paused: counter parks at zero so a re-enable restarts a full period.
      count_d = '0;
      tick_d  = i_force;
    end
  end

  // Counter and tick registers.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign o_fire = tick_d;
  assign o_tick = tick_q;

endmodule

// File: rtl/led_seq_ctrl.sv
// LED bank sequencer: run/pause FSM, prescaled step ticks and the pattern/mode engine.
// Optional single-step input i_step is enabled by defining LED_SEQ_STEP_EN.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int          NB_LEDS  = 4,
  parameter int          NB_COUNT = 32,
  parameter int unsigned CNT_BASE = 32'd50000000
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [1:0]         i_speed_sel,
  input  logic [1:0]         i_mode,
`ifdef LED_SEQ_STEP_EN
  input  logic               i_step,
`endif
  output logic [NB_LEDS-1:0] o_led,
  output logic               o_tick,
  output logic [1:0]         o_mode
);

  localparam logic [NB_LEDS-1:0] LED_ONES = {NB_LEDS{1'b1}};
  localparam logic [NB_LEDS-1:0] LED_LSB  = {{(NB_LEDS-1){1'b0}}, 1'b1};
  localparam logic [NB_LEDS-1:0] LED_MSB  = {1'b1, {(NB_LEDS-1){1'b0}}};

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  dir_e                dir_q, dir_d;
  logic [NB_LEDS-1:0]  led_q, led_d;
  mode_e               req_mode_s;
  logic                run_s;
  logic                step_s;
  logic                fire_s;
  logic                tick_s;

  // Gating with i_enable means a falling enable on the wrap edge suppresses that tick.
  assign run_s = (state_q == ST_RUN) && i_enable;

`ifdef LED_SEQ_STEP_EN
  assign step_s = (state_q == ST_IDLE) && i_step;
`else
  assign step_s = 1'b0;
`endif

  led_seq_prescaler #(
    .NB_COUNT (NB_COUNT),
    .CNT_BASE (CNT_BASE)
  ) u_prescaler (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_run       (run_s),
    .i_force     (step_s),
    .i_speed_sel (i_speed_sel),
    .o_fire      (fire_s),
    .o_tick      (tick_s)
  );

  // Run/pause state transitions.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_enable) state_d = ST_RUN;
        else          state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (i_enable) state_d = ST_RUN;
        else          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pattern engine: on a tick either load the requested mode's seed or advance one step.
  always_comb begin
    led_d      = led_q;
    mode_d     = mode_q;
    dir_d      = dir_q;
    req_mode_s = mode_e'(i_mode);
    if (fire_s) begin
      if (req_mode_s != mode_q) begin
        mode_d = req_mode_s;
        case (req_mode_s)
          MODE_FLASH:    led_d = LED_ONES;
          MODE_SHIFT_L:  led_d = LED_LSB;
          MODE_SHIFT_R:  led_d = LED_MSB;
          MODE_PINGPONG: begin
            led_d = LED_LSB;
            dir_d = DIR_LEFT;
          end
          default: begin
            led_d  = LED_ONES;
            mode_d = MODE_FLASH;
          end
        endcase
      end else begin
        case (mode_q)
          MODE_FLASH:   led_d = ~led_q;
          MODE_SHIFT_L: led_d = {led_q[NB_LEDS-2:0], led_q[NB_LEDS-1]};
          MODE_SHIFT_R: led_d = {led_q[0], led_q[NB_LEDS-1:1]};
          MODE_PINGPONG: begin
            // Turn around on the edge the lit bit lands on an end, so the end shows once.
            if (dir_q == DIR_LEFT) begin
              led_d = {led_q[NB_LEDS-2:0], 1'b0};
              if (led_d[NB_LEDS-1]) dir_d = DIR_RIGHT;
              else                  dir_d = DIR_LEFT;
            end else begin
              led_d = {1'b0, led_q[NB_LEDS-1:1]};
              if (led_d[0]) dir_d = DIR_LEFT;
              else          dir_d = DIR_RIGHT;
            end
          end
          default: begin
            led_d  = LED_ONES;
            mode_d = MODE_FLASH;
          end
        endcase
      end
    end else begin
      led_d  = led_q;
      mode_d = mode_q;
      dir_d  = dir_q;
    end
  end

  // State, pattern, mode and direction registers.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      led_q   <= LED_ONES;
      mode_q  <= MODE_FLASH;
      dir_q   <= DIR_LEFT;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
    end
  end

  assign o_led  = led_q;
  assign o_mode = mode_q;
  assign o_tick = tick_s;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl (NB_LEDS=4, CNT_BASE=4): expected ticks are queued
// with their pattern, mode and cycle, and popped whenever the DUT raises o_tick.
module tb_led_seq_ctrl;

  typedef struct {
    logic [3:0] led;
    logic [1:0] mode;
    int         cyc;
  } exp_t;

  logic       clock = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_enable = 1'b0;
  logic [1:0] i_speed_sel = 2'd0;
  logic [1:0] i_mode = 2'd0;
`ifdef LED_SEQ_STEP_EN
  logic       i_step = 1'b0;
`endif
  logic [3:0] o_led;
  logic       o_tick;
  logic [1:0] o_mode;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  led_seq_ctrl #(
    .NB_LEDS  (4),
    .NB_COUNT (32),
    .CNT_BASE (32'd4)
  ) dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_speed_sel (i_speed_sel),
    .i_mode      (i_mode),
`ifdef LED_SEQ_STEP_EN
    .i_step      (i_step),
`endif
    .o_led       (o_led),
    .o_tick      (o_tick),
    .o_mode      (o_mode)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [3:0] led, input logic [1:0] mode, input int at);
    exp_t e;
    e.led  = led;
    e.mode = mode;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clock);
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    i_reset  = 1'b1;
    i_enable = 1'b0;
    @(negedge clock);
    i_reset  = 1'b0;
  endtask

  // Monitor: every observed tick must match the head of the scoreboard.
  always @(negedge clock) begin
    if (o_tick === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_tick", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("tick_led", o_led, e.led);
        check_eq("tick_mode", o_mode, e.mode);
        check_eq("tick_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int c;
    // Reset values.
    repeat (2) @(negedge clock);
    check_eq("rst_led", o_led, 4'b1111);
    check_eq("rst_tick", o_tick, 1'b0);
    check_eq("rst_mode", o_mode, 2'd0);
    i_reset = 1'b0;

    // FLASH at speed 0.
    @(negedge clock);
    c = cyc;
    push_exp(4'b0000, 2'd0, c + 5);
    push_exp(4'b1111, 2'd0, c + 9);
    i_mode = 2'd0; i_speed_sel = 2'd0; i_enable = 1'b1;
    wait_drain("flash_drain", 40);
    i_enable = 1'b0;

    // SHIFT_L from reset, with a mid-period mode glitch that must be ignored.
    do_reset();
    c = cyc;
    push_exp(4'b0001, 2'd1, c + 5);
    push_exp(4'b0010, 2'd1, c + 9);
    push_exp(4'b0100, 2'd1, c + 13);
    push_exp(4'b1000, 2'd1, c + 17);
    push_exp(4'b0001, 2'd1, c + 21);
    i_mode = 2'd1; i_enable = 1'b1;
    wait_until(c + 10);
    i_mode = 2'd3;
    wait_until(c + 12);
    i_mode = 2'd1;
    wait_drain("shl_drain", 60);
    i_enable = 1'b0;

    // PINGPONG bounces with each end shown for one tick.
    do_reset();
    c = cyc;
    push_exp(4'b0001, 2'd3, c + 5);
    push_exp(4'b0010, 2'd3, c + 9);
    push_exp(4'b0100, 2'd3, c + 13);
    push_exp(4'b1000, 2'd3, c + 17);
    push_exp(4'b0100, 2'd3, c + 21);
    push_exp(4'b0010, 2'd3, c + 25);
    push_exp(4'b0001, 2'd3, c + 29);
    push_exp(4'b0010, 2'd3, c + 33);
    i_mode = 2'd3; i_enable = 1'b1;
    wait_drain("pp_drain", 80);
    i_enable = 1'b0;

    // Speed 3 down to speed 0 at counter 20 forces an immediate wrap.
    do_reset();
    c = cyc;
    push_exp(4'b0000, 2'd0, c + 22);
    push_exp(4'b1111, 2'd0, c + 26);
    push_exp(4'b0000, 2'd0, c + 30);
    i_mode = 2'd0; i_speed_sel = 2'd3; i_enable = 1'b1;
    wait_until(c + 21);
    i_speed_sel = 2'd0;
    wait_drain("speed_drain", 40);
    i_enable = 1'b0;

    // SHIFT_R with a pause at counter 2, then a reset at pattern 0100.
    do_reset();
    c = cyc;
    push_exp(4'b1000, 2'd2, c + 5);
    push_exp(4'b0100, 2'd2, c + 9);
    push_exp(4'b0010, 2'd2, c + 26);
    push_exp(4'b0001, 2'd2, c + 30);
    push_exp(4'b1000, 2'd2, c + 34);
    push_exp(4'b0100, 2'd2, c + 38);
    push_exp(4'b1000, 2'd2, c + 45);
    i_mode = 2'd2; i_enable = 1'b1;
    wait_until(c + 11);
    i_enable = 1'b0;
    wait_until(c + 15);
    check_eq("pause_led_a", o_led, 4'b0100);
    wait_until(c + 21);
    check_eq("pause_led_b", o_led, 4'b0100);
    check_eq("pause_tick", o_tick, 1'b0);
    i_enable = 1'b1;
    wait_until(c + 39);
    check_eq("pre_rst_led", o_led, 4'b0100);
    i_reset = 1'b1;
    wait_until(c + 40);
    check_eq("mid_rst_led", o_led, 4'b1111);
    check_eq("mid_rst_mode", o_mode, 2'd0);
    check_eq("mid_rst_tick", o_tick, 1'b0);
    i_reset = 1'b0;
    wait_drain("shr_drain", 40);
    i_enable = 1'b0;

    // Enable falling on the wrap edge: no tick, pattern held.
    do_reset();
    c = cyc;
    push_exp(4'b0000, 2'd0, c + 5);
    i_mode = 2'd0; i_enable = 1'b1;
    wait_until(c + 8);
    i_enable = 1'b0;
    wait_until(c + 14);
    check_eq("wrap_off_led", o_led, 4'b0000);
    check_eq("wrap_off_tick", o_tick, 1'b0);
    wait_drain("wrap_off_drain", 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
